sqrt_datapath: RTL and testbench
================================

SQRT_DATAPATH -- requirements
Module: sqrt_datapath

Interface
REQ-001 Parameter WIDTH, default 8, radicand width in bits; SHALL be even and at least 4.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port a_ld, input, 1, load radicand and initialise the iteration registers.
REQ-005 Port sq_ld, input, 1, square register update strobe.
REQ-006 Port del_ld, input, 1, delta register update strobe.
REQ-007 Port root_ld, input, 1, result capture strobe.
REQ-008 Port a_in, input, WIDTH, radicand, sampled only when a_ld=1.
REQ-009 Port lseq_flag, output, 1, high when square <= radicand (to control unit).
REQ-010 Port root, output, WIDTH/2, registered integer square root.
REQ-011 Port root_valid, output, 1, root holds the result for the current radicand.
REQ-012 Port done, output, 1, one-cycle completion pulse.

Function
REQ-013 Internal registers SHALL be a_reg (WIDTH), sq_reg (WIDTH+1), del_reg (WIDTH/2+2), so that no overflow occurs for any a_in.
REQ-014 On a clock edge with a_ld=1: a_reg<=a_in, sq_reg<=1, del_reg<=3, root_valid<=0; sq_ld, del_ld and root_ld SHALL be ignored that cycle (a_ld has priority).
REQ-015 On an edge with a_ld=0 and sq_ld=1: sq_reg<=sq_reg+del_reg.
REQ-016 On an edge with a_ld=0 and del_ld=1: del_reg<=del_reg+2; sq_ld and del_ld SHALL act independently, each using pre-edge register values.
REQ-017 On an edge with a_ld=0 and root_ld=1: root<=(del_reg>>1)-1, truncated to WIDTH/2, using pre-edge del_reg, even if sq_ld/del_ld are also high; root_valid<=1.
REQ-018 lseq_flag SHALL be combinational: (sq_reg <= zero-extended a_reg), unsigned; zero added latency.
REQ-019 done SHALL be high for exactly the one cycle following each edge that sampled root_ld=1 with a_ld=0; back-to-back root_ld SHALL give back-to-back done.
REQ-020 root SHALL hold its value until the next accepted root_ld; a_ld clears only root_valid, not root.
REQ-021 With all strobes low, every register SHALL hold its value.
REQ-022 Intended sequence: one a_ld, then repeated sq_ld+del_ld pairs while lseq_flag=1, then one root_ld; result equals floor(sqrt(a_in)) for all a_in in 0..2^WIDTH-1.
REQ-023 Boundary: a_in=0 gives lseq_flag=0 immediately after load; root_ld then yields root=0.
REQ-024 Boundary: a_in=2^WIDTH-1 SHALL drive sq_reg to exactly 2^WIDTH without wrap, lseq_flag=0, root=2^(WIDTH/2)-1.

Reset
REQ-025 rst_n low SHALL asynchronously force a_reg=0, sq_reg=1, del_reg=3, root=0, root_valid=0, done=0.
REQ-026 Reset asserted mid-iteration SHALL abandon the computation; after release the block SHALL need a fresh a_ld before a meaningful root_ld.
REQ-027 After reset, lseq_flag SHALL read 0 (sq_reg=1 > a_reg=0).

Structure
REQ-028 Package sqrt_pkg SHALL hold the default WIDTH and the init constants SQ_INIT=1, DEL_INIT=3, DEL_STEP=2, shared with the control unit and top level.
REQ-029 No sub-module; one adder per register, one comparator, one shift/decrement; sqrt_top integrates this block with the control unit.

Verification
REQ-030 a_in=16, a_ld, then sq_ld+del_ld pairs while lseq_flag=1 (4 pairs), root_ld -> root=4, root_valid=1, done pulses once.
REQ-031 a_in=0, a_ld -> lseq_flag=0; root_ld -> root=0; a_in=1 -> 1 pair, root=1.
REQ-032 a_in=255 (WIDTH=8) -> 15 pairs, sq_reg=256 no wrap, root=15; a_in=200 -> root=14; a_in=15 -> root=3.
REQ-033 a_ld asserted together with sq_ld, del_ld, root_ld -> sq_reg=1, del_reg=3, root unchanged, root_valid=0, no done.
REQ-034 rst_n pulsed low mid-iteration for a_in=100 -> all registers to reset values immediately (no clock); new a_ld with a_in=100 then full sequence -> root=10.
REQ-035 Exhaustive sweep a_in=0..255 against floor(sqrt) reference model, including root_ld coincident with sq_ld/del_ld using pre-edge del_reg.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared constants for the integer square-root datapath, its control unit and the top level.
// The iteration walks consecutive odd numbers: sq tracks (k+1)^2 and del tracks 2k+3.
package sqrt_pkg;

   localparam int SQRT_WIDTH = 8;

   localparam int SQ_INIT  = 1;
   localparam int DEL_INIT = 3;
   localparam int DEL_STEP = 2;

endpackage

// File: rtl/sqrt_datapath.sv
// Integer square-root datapath: accumulates odd numbers into a square register until it exceeds
// the radicand; the control unit sequences the strobes and reads lseq_flag back.
module sqrt_datapath
   import sqrt_pkg::*;
#(
   parameter int WIDTH = SQRT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               a_ld,
   input  logic               sq_ld,
   input  logic               del_ld,
   input  logic               root_ld,
   input  logic [WIDTH-1:0]   a_in,
   output logic               lseq_flag,
   output logic [WIDTH/2-1:0] root,
   output logic               root_valid,
   output logic               done
);

   localparam int SW = WIDTH + 1;
   localparam int DW = WIDTH / 2 + 2;
   localparam int HW = WIDTH / 2;

   logic [WIDTH-1:0] a_reg;
   logic [SW-1:0]    sq_reg;
   logic [DW-1:0]    del_reg;
   logic [HW-1:0]    root_next;

   // del is always 2*root+3 at the end of the loop, so the root falls out of del/2 - 1
   assign root_next = HW'((del_reg >> 1) - DW'(1));
   assign lseq_flag = (sq_reg <= {1'b0, a_reg});

   // a_ld restarts the iteration and masks every other strobe in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         sq_reg     <= SW'(SQ_INIT);
         del_reg    <= DW'(DEL_INIT);
         root       <= '0;
         root_valid <= 1'b0;
         done       <= 1'b0;
      end else if (a_ld) begin
         a_reg      <= a_in;
         sq_reg     <= SW'(SQ_INIT);
         del_reg    <= DW'(DEL_INIT);
         root_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (sq_ld)
            sq_reg <= sq_reg + SW'(del_reg);
         if (del_ld)
            del_reg <= del_reg + DW'(DEL_STEP);
         if (root_ld) begin
            root       <= root_next;
            root_valid <= 1'b1;
         end
         done <= root_ld;
      end
   end

endmodule

// File: tb/tb_sqrt_datapath.sv
// Directed bench for sqrt_datapath: hand-picked radicands, strobe priority, async reset and a
// full 8-bit sweep against a brute-force floor(sqrt) reference.
module tb_sqrt_datapath;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               a_ld = 1'b0;
   logic               sq_ld = 1'b0;
   logic               del_ld = 1'b0;
   logic               root_ld = 1'b0;
   logic [WIDTH-1:0]   a_in = '0;
   logic               lseq_flag;
   logic [WIDTH/2-1:0] root;
   logic               root_valid;
   logic               done;

   int checks = 0;
   int errors = 0;
   int pairs;

   sqrt_datapath #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_ld       (a_ld),
      .sq_ld      (sq_ld),
      .del_ld     (del_ld),
      .root_ld    (root_ld),
      .a_in       (a_in),
      .lseq_flag  (lseq_flag),
      .root       (root),
      .root_valid (root_valid),
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v)
         r++;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Drive strobes for exactly one rising edge; returns at the following falling edge.
   task automatic applyStimulus(input logic l, input logic s, input logic d, input logic r,
                                input int v);
      a_ld    = l;
      sq_ld   = s;
      del_ld  = d;
      root_ld = r;
      a_in    = WIDTH'(v);
      @(posedge clk);
      @(negedge clk);
      a_ld    = 1'b0;
      sq_ld   = 1'b0;
      del_ld  = 1'b0;
      root_ld = 1'b0;
   endtask

   // Full load / iterate / capture sequence; optionally overlap the capture with one more pair.
   task automatic runSqrt(input int v, input bit coincide, output int n);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, v);
      n = 0;
      while (lseq_flag && n < 20) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, v);
         n++;
      end
      applyStimulus(1'b0, coincide, coincide, 1'b1, v);
   endtask

   initial begin
      #12;
      checkOutput("reset_lseq", int'(lseq_flag), 0);
      checkOutput("reset_root", int'(root), 0);
      checkOutput("reset_valid", int'(root_valid), 0);
      checkOutput("reset_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      runSqrt(16, 1'b0, pairs);
      checkOutput("a16_pairs", pairs, 4);
      checkOutput("a16_root", int'(root), 4);
      checkOutput("a16_valid", int'(root_valid), 1);
      checkOutput("a16_done", int'(done), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("a16_done_drop", int'(done), 0);
      checkOutput("a16_hold", int'(root), 4);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
      checkOutput("a0_lseq", int'(lseq_flag), 0);
      checkOutput("a0_valid_clr", int'(root_valid), 0);
      checkOutput("a0_root_kept", int'(root), 4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0);
      checkOutput("a0_root", int'(root), 0);

      runSqrt(1, 1'b0, pairs);
      checkOutput("a1_pairs", pairs, 1);
      checkOutput("a1_root", int'(root), 1);

      runSqrt(255, 1'b0, pairs);
      checkOutput("a255_pairs", pairs, 15);
      checkOutput("a255_lseq", int'(lseq_flag), 0);
      checkOutput("a255_root", int'(root), 15);

      runSqrt(200, 1'b0, pairs);
      checkOutput("a200_root", int'(root), 14);
      runSqrt(15, 1'b0, pairs);
      checkOutput("a15_root", int'(root), 3);

      // a_ld must win over every other strobe
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2);
      checkOutput("prio_root", int'(root), 3);
      checkOutput("prio_valid", int'(root_valid), 0);
      checkOutput("prio_done", int'(done), 0);
      checkOutput("prio_lseq", int'(lseq_flag), 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2);
      checkOutput("prio_lseq_after", int'(lseq_flag), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2);
      checkOutput("prio_root_after", int'(root), 1);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 100);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 100);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_root", int'(root), 0);
      checkOutput("rst_valid", int'(root_valid), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_lseq", int'(lseq_flag), 0);
      @(negedge clk);
      rst_n = 1'b1;
      runSqrt(100, 1'b0, pairs);
      checkOutput("a100_pairs", pairs, 10);
      checkOutput("a100_root", int'(root), 10);

      for (int v = 0; v < (1 << WIDTH); v++) begin
         runSqrt(v, v[0], pairs);
         checkOutput($sformatf("sweep_pairs_%0d", v), pairs, isqrt(v));
         checkOutput($sformatf("sweep_root_%0d", v), int'(root), isqrt(v));
         checkOutput($sformatf("sweep_done_%0d", v), int'(done), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
